shift_normalizer: RTL and testbench

Multi-cycle 32-bit normalizer: it is the inverse companion of the barrel-shifter stages. Given an operand, it finds how far the operand must be shifted left to become normalized, and returns both the normalized value and the shift count. It sits beside the shifter datapath and feeds the count to later shift/scale logic. Internally it shifts left by 4 per cycle (coarse), then by 1 per cycle (fine), under a valid/ready handshake on both sides.

---
 rtl/shift_normalizer_pkg.sv | 9 +
 rtl/shift_normalizer_norm_shift_step.sv | 18 +
 rtl/shift_normalizer.sv | 73 +++++++
 tb/tb_shift_normalizer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/shift_normalizer_pkg.sv
// shift_normalizer_pkg: shared widths, limits and FSM states for the normalizer (package shift_pkg)
package shift_pkg;
  localparam int WIDTH = 32;
  localparam int COARSE = 4;
  localparam int COUNT_W = 6;
  localparam logic [COUNT_W-1:0] LIMIT_U = 6'd32;
  localparam logic [COUNT_W-1:0] LIMIT_S = 6'd31;
  typedef enum logic [1:0] {S_IDLE, S_COARSE, S_FINE, S_DONE} state_e;
endpackage

// File: rtl/shift_normalizer_norm_shift_step.sv
// norm_shift_step: one zero-fill left shift (COARSE or 1 bit) plus redundancy/normalized flags
// ports: val_i operand, signed_i mode, coarse_i step select, val_o shifted, redundant_o top nibble redundant, norm_o normalized
module norm_shift_step
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] val_i,
  input  logic             signed_i,
  input  logic             coarse_i,
  output logic [WIDTH-1:0] val_o,
  output logic             redundant_o,
  output logic             norm_o
);
  assign val_o = coarse_i ? val_i << COARSE : val_i << 1;
  // signed needs five equal top bits so the sign survives a 4-bit shift
  assign redundant_o = signed_i ? (&val_i[WIDTH-1:WIDTH-5] | ~|val_i[WIDTH-1:WIDTH-5])
                                : ~|val_i[WIDTH-1:WIDTH-4];
  assign norm_o = signed_i ? val_i[WIDTH-1] ^ val_i[WIDTH-2] : val_i[WIDTH-1];
endmodule

// File: rtl/shift_normalizer.sv
// shift_normalizer: multi-cycle normalizer returning normalized value and left-shift count
// ports: clk, rst_n (async low), in_valid_i/in_ready_o/signed_i/in_data_i accept side,
//        out_valid_o/out_ready_i/out_data_o/count_o result side
module shift_normalizer
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [COUNT_W-1:0] count_o
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d, step_val;
  logic [COUNT_W-1:0] cnt_q, cnt_d, limit;
  logic sgn_q, sgn_d, redundant, norm, coarse_ok;
  norm_shift_step u_step (
    .val_i      (val_q),
    .signed_i   (sgn_q),
    .coarse_i   (state_q == S_COARSE),
    .val_o      (step_val),
    .redundant_o(redundant),
    .norm_o     (norm)
  );
  assign limit = sgn_q ? LIMIT_S : LIMIT_U;
  assign coarse_ok = redundant && ({1'b0, cnt_q} + 7'(COARSE) <= {1'b0, limit});
  always_comb begin
    state_d = state_q;
    val_d = val_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    case (state_q)
      S_IDLE: if (in_valid_i) begin
        val_d = in_data_i;
        sgn_d = signed_i;
        cnt_d = '0;
        state_d = S_COARSE;
      end
      S_COARSE: if (coarse_ok) begin
        val_d = step_val;
        cnt_d = cnt_q + COUNT_W'(COARSE);
      end else state_d = S_FINE;
      S_FINE: if (!norm && cnt_q < limit) begin
        val_d = step_val;
        cnt_d = cnt_q + 1'b1;
      end else state_d = S_DONE;
      S_DONE: if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
    end
  end
  assign in_ready_o = state_q == S_IDLE;
  assign out_valid_o = state_q == S_DONE;
  assign out_data_o = val_q;
  assign count_o = cnt_q;
endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: scoreboard bench with a leading-bit-count reference model
module tb_shift_normalizer;
  logic clk = 0, rst_n = 0, in_valid = 0, sgn = 0, out_ready = 0;
  logic [31:0] din = 0;
  logic in_ready, out_valid;
  logic [31:0] dout;
  logic [5:0] count;
  shift_normalizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .signed_i(sgn), .in_data_i(din), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(dout), .count_o(count)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [31:0] d; int c; int lat; int acc;} exp_t;
  exp_t sbq[$];
  exp_t cur;
  bit held = 0;
  int total = 0, bad = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // count = redundant leading bits (zeros, or sign copies beyond the sign bit), capped at the limit
  function automatic exp_t model(input logic [31:0] x, input bit s);
    exp_t e;
    int c = 0;
    if (!s) while (c < 32 && x[31-c] == 1'b0) c++;
    else while (c < 31 && x[30-c] == x[31]) c++;
    e.c = c;
    e.d = (c >= 32) ? 32'h0 : x << c;
    e.lat = c / 4 + c % 4 + 2;
    e.acc = 0;
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) held = 0;
    else if (out_valid) begin
      if (!held) begin
        held = 1;
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
          cur.d = dout; cur.c = count; cur.lat = 0; cur.acc = cyc;
        end else begin
          cur = sbq.pop_front();
          chk("latency", cyc - cur.acc, cur.lat);
        end
      end
      chk("out_data", dout, cur.d);
      chk("count", count, cur.c);
      chk("in_ready_in_done", in_ready, 0);
    end else held = 0;
  end
  task automatic run(input logic [31:0] x, input bit s, input int hold);
    exp_t e = model(x, s);
    int n = 0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; din = x; sgn = s;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sbq.push_back(e);
    in_valid = 0; din = $urandom; sgn = 1'($urandom);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("timeout", 0, 1);
      sbq.delete();
      return;
    end
    repeat (hold) begin
      in_valid = 1; din = $urandom;
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);
    chk("out_valid_after_release", out_valid, 0);
  endtask
  initial begin
    logic [31:0] r;
    bit s;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", dout, 0);
    chk("rst_count", count, 0);
    rst_n = 1;
    run(32'h00000001, 0, 5);
    run(32'h00000000, 0, 0);
    run(32'h00000000, 1, 1);
    run(32'hFFFFFFF0, 1, 2);
    run(32'h00000003, 1, 0);
    run(32'h80000000, 0, 0);
    run(32'h40000000, 1, 3);
    run(32'hFFFFFFFF, 1, 0);
    @(negedge clk);
    in_valid = 1; din = 32'h1; sgn = 0;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_count", count, 0);
    chk("abort_data", dout, 0);
    @(negedge clk);
    rst_n = 1;
    run(32'h0000F000, 0, 1);
    for (int i = 0; i < 60; i++) begin
      r = $urandom >> $urandom_range(0, 32);
      s = 1'($urandom_range(0, 1));
      if (s && $urandom_range(0, 1) == 1) r = ~r;
      run(r, s, $urandom_range(0, 3));
    end
    if (sbq.size() != 0) chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
